// File: rtl/game_controller_array.sv
// Multi-player controller front end: button debounce, stick sync, facing direction, rumble bursts, ADC clock.
// Stick data lags 2 cycles and buttons lag 2+DEBOUNCE_CYCLES cycles; there is no backpressure, so requests are sampled only while a player is idle.
module game_controller_array #(
    parameter int NUM_PLAYERS     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ADC_DIV         = 64,
    parameter int PULSE_LEN       = 2000000,
    parameter int PULSE_COUNT     = 3
) (
    input  logic                      fastClock,
    input  logic                      reset,
    input  logic [18*NUM_PLAYERS-1:0] gpio,
    input  logic [32*NUM_PLAYERS-1:0] mmioBoardOutput,
    input  logic [NUM_PLAYERS-1:0]    startDir,
    output logic [32*NUM_PLAYERS-1:0] mmioBoardInput,
    output logic [NUM_PLAYERS-1:0]    ledMotorOut,
    output logic                      slowClock
);

    localparam int HALF = ADC_DIV / 2;
    localparam int SCW  = $clog2(HALF);
    localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PHW  = $clog2(PULSE_LEN + 1);
    localparam int BW   = $clog2(PULSE_COUNT + 1);

    localparam logic [SCW-1:0] DIV_LAST   = SCW'(HALF - 1);
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PHW-1:0] PH_LAST    = PHW'(PULSE_LEN - 1);
    localparam logic [BW-1:0]  BURST_LAST = BW'(PULSE_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_OFF
    } rumble_state_e;

    logic [SCW-1:0] div_q;
    logic           slow_q;
    logic           slow_tick;

    // The tick marks the fastClock edge on which slowClock rises, so direction sampling stays in one clock domain.
    assign slow_tick = (div_q == DIV_LAST) && !slow_q;
    assign slowClock = slow_q;

    always_ff @(posedge fastClock or negedge reset) begin
        if (!reset) begin
            div_q  <= '0;
            slow_q <= 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_q  <= '0;
            slow_q <= ~slow_q;
        end else begin
            div_q  <= div_q + 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [9:0]     btn_raw;
        logic [9:0]     btn_s1_q, btn_s2_q, btn_q;
        logic [DBW-1:0] db_cnt_q [10];
        logic [3:0]     x_s1_q, x_s2_q, y_s1_q, y_s2_q;
        logic           dir_q;
        logic           req;
        logic           busy;
        logic           unused_mmio;

        rumble_state_e  state_q, state_d;
        logic [PHW-1:0] phase_q, phase_d;
        logic [BW-1:0]  burst_q, burst_d;

        // Debounced bits are kept in status-word order: buttons, D-pad, reset/jump.
        assign btn_raw     = {gpio[18*p+16 +: 2], gpio[18*p+8 +: 4], gpio[18*p +: 4]};
        assign req         = mmioBoardOutput[32*p];
        assign unused_mmio = ^mmioBoardOutput[32*p+1 +: 31];

        always_ff @(posedge fastClock or negedge reset) begin
            if (!reset) begin
                btn_s1_q <= '0;
                btn_s2_q <= '0;
                btn_q    <= '0;
                x_s1_q   <= '0;
                x_s2_q   <= '0;
                y_s1_q   <= '0;
                y_s2_q   <= '0;
                for (int b = 0; b < 10; b++) begin
                    db_cnt_q[b] <= '0;
                end
            end else begin
                btn_s1_q <= btn_raw;
                btn_s2_q <= btn_s1_q;
                x_s1_q   <= gpio[18*p+4 +: 4];
                x_s2_q   <= x_s1_q;
                y_s1_q   <= gpio[18*p+12 +: 4];
                y_s2_q   <= y_s1_q;
                for (int b = 0; b < 10; b++) begin
                    if (btn_s2_q[b] != btn_q[b]) begin
                        if (db_cnt_q[b] == DB_LAST) begin
                            btn_q[b]    <= btn_s2_q[b];
                            db_cnt_q[b] <= '0;
                        end else begin
                            db_cnt_q[b] <= db_cnt_q[b] + 1'b1;
                        end
                    end else begin
                        db_cnt_q[b] <= '0;
                    end
                end
            end
        end

        always_ff @(posedge fastClock or negedge reset) begin
            if (!reset) begin
                dir_q <= startDir[p];
            end else if (slow_tick) begin
                if (y_s2_q[3:2] == 2'b00) begin
                    dir_q <= 1'b0;
                end else if (y_s2_q[3:2] == 2'b11) begin
                    dir_q <= 1'b1;
                end
            end
        end

        always_ff @(posedge fastClock or negedge reset) begin
            if (!reset) begin
                state_q <= ST_IDLE;
                phase_q <= '0;
                burst_q <= '0;
            end else begin
                state_q <= state_d;
                phase_q <= phase_d;
                burst_q <= burst_d;
            end
        end

        // Requests are level-sensitive in IDLE only; a held request restarts after one idle cycle.
        always_comb begin
            state_d = state_q;
            phase_d = phase_q;
            burst_d = burst_q;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        state_d = ST_ON;
                        phase_d = '0;
                        burst_d = BW'(1);
                    end
                end
                ST_ON: begin
                    if (phase_q == PH_LAST) begin
                        state_d = ST_OFF;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                ST_OFF: begin
                    if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        if (burst_q == BURST_LAST) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_ON;
                            burst_d = burst_q + 1'b1;
                        end
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        assign busy           = (state_q != ST_IDLE);
        assign ledMotorOut[p] = (state_q == ST_ON);
        assign mmioBoardInput[32*p +: 32] = {4'b0000, busy, dir_q, btn_q, y_s2_q,
                                             4'b0000, x_s2_q, 4'b0000};
    end

endmodule

// File: tb/tb_game_controller_array.sv
// Directed bench for game_controller_array with short parameters: vector table plus multi-cycle sequences.
module tb_game_controller_array;

    localparam int NP = 2;
    localparam logic [31:0] DATA_MASK = 32'h03FF_FFFF;

    logic            fastClock = 1'b0;
    logic            reset;
    logic [18*NP-1:0] gpio;
    logic [32*NP-1:0] mmioBoardOutput;
    logic [NP-1:0]    startDir;
    logic [32*NP-1:0] mmioBoardInput;
    logic [NP-1:0]    ledMotorOut;
    logic             slowClock;

    logic [31:0] w0, w1;
    assign w0 = mmioBoardInput[31:0];
    assign w1 = mmioBoardInput[63:32];

    game_controller_array #(
        .NUM_PLAYERS    (NP),
        .DEBOUNCE_CYCLES(3),
        .ADC_DIV        (8),
        .PULSE_LEN      (4),
        .PULSE_COUNT    (3)
    ) dut (
        .fastClock      (fastClock),
        .reset          (reset),
        .gpio           (gpio),
        .mmioBoardOutput(mmioBoardOutput),
        .startDir       (startDir),
        .mmioBoardInput (mmioBoardInput),
        .ledMotorOut    (ledMotorOut),
        .slowClock      (slowClock)
    );

    always #5 fastClock = ~fastClock;

    int checks = 0;
    int errors = 0;
    int n = 0;

    typedef struct {
        logic [17:0] g0;
        logic [17:0] g1;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, n);
        end
    endtask

    task automatic tick();
        @(posedge fastClock);
        #1;
        n++;
    endtask

    initial begin
        // gpio fields: {reset/jump, y, D-pad, x, buttons}
        vecs[0] = '{g0: 18'h35AC3, g1: 18'h0F0F0, w0: 32'h03A3_50C0, w1: 32'h0000_F0F0};
        vecs[1] = '{g0: 18'h19618, g1: 18'h20F0F, w0: 32'h0168_9010, w1: 32'h02FF_0000};
        vecs[2] = '{g0: 18'h00000, g1: 18'h00000, w0: 32'h0000_0000, w1: 32'h0000_0000};
        vecs[3] = '{g0: 18'h3FFFF, g1: 18'h00000, w0: 32'h03FF_F0F0, w1: 32'h0000_0000};

        reset           = 1'b0;
        gpio            = '0;
        mmioBoardOutput = '0;
        startDir        = 2'b10;

        repeat (3) @(posedge fastClock);
        #1;
        check("rst_w0", w0, 32'h0);
        check("rst_w1", w1, 32'h0400_0000);
        check("rst_led", 32'(ledMotorOut), 32'h0);
        check("rst_slow", 32'(slowClock), 32'h0);
        @(negedge fastClock);
        reset = 1'b1;
        n = 0;
        #1;
        check("rel_w1", w1, 32'h0400_0000);

        // slowClock rises after edges 4, 12, 20...; player1 faces left from the first tick (y=0)
        for (int i = 1; i <= 40; i++) begin
            tick();
            check("slowclk", 32'(slowClock), 32'((n % 8) >= 4));
            check("dir1_first_tick", 32'(w1[26]), 32'(n < 4));
        end

        for (int v = 0; v < 4; v++) begin
            gpio = {vecs[v].g1, vecs[v].g0};
            repeat (8) tick();
            check($sformatf("vec%0d_w0", v), w0 & DATA_MASK, vecs[v].w0);
            check($sformatf("vec%0d_w1", v), w1 & DATA_MASK, vecs[v].w1);
        end

        gpio = '0;
        repeat (8) tick();
        gpio[17:0] = 18'h000A0;
        tick();
        check("stick_lat1", 32'(w0[7:4]), 32'h0);
        tick();
        check("stick_lat2", 32'(w0[7:4]), 32'hA);

        gpio = '0;
        while ((n % 8) != 4) tick();
        repeat (8) tick();
        check("dir0_y0", 32'(w0[26]), 32'h0);
        check("dir1_y0", 32'(w1[26]), 32'h0);
        gpio = {18'h06000, 18'h06000};
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("dir0_y6_hold", 32'(w0[26]), 32'h0);
            check("dir1_y6_hold", 32'(w1[26]), 32'h0);
        end
        gpio = {18'h0F000, 18'h0F000};
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("dir0_yF", 32'(w0[26]), 32'(i == 8));
            check("dir1_yF", 32'(w1[26]), 32'(i == 8));
        end

        gpio = '0;
        repeat (8) tick();
        begin
            logic seen;
            seen = 1'b0;
            gpio[0] = 1'b1;
            tick();
            tick();
            gpio[0] = 1'b0;
            repeat (10) begin
                tick();
                seen = seen | w0[16];
            end
            check("db_glitch", 32'(seen), 32'h0);
        end
        gpio[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("db_rise", 32'(w0[16]), 32'(k >= 5));
        end
        gpio[0] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("db_fall", 32'(w0[16]), 32'(k < 5));
        end

        // Single-cycle request on player0; player1 sees only ignored upper bits
        gpio = '0;
        mmioBoardOutput = {32'hFFFF_FFFE, 32'h0};
        tick();
        mmioBoardOutput[0] = 1'b1;
        tick();
        mmioBoardOutput[0] = 1'b0;
        for (int i = 0; i < 28; i++) begin
            check("rumble_led0", 32'(ledMotorOut[0]), 32'((i < 24) && ((i % 8) < 4)));
            check("rumble_busy0", 32'(w0[27]), 32'(i < 24));
            check("rumble_led1", 32'(ledMotorOut[1]), 32'h0);
            check("rumble_busy1", 32'(w1[27]), 32'h0);
            if (i == 10) mmioBoardOutput[0] = 1'b1;
            if (i == 11) mmioBoardOutput[0] = 1'b0;
            tick();
        end

        mmioBoardOutput = {32'h1, 32'h1};
        tick();
        for (int i = 0; i < 27; i++) begin
            check("held_led0", 32'(ledMotorOut[0]), 32'((i < 24) ? ((i % 8) < 4) : (i >= 25)));
            check("held_led1", 32'(ledMotorOut[1]), 32'((i < 24) ? ((i % 8) < 4) : (i >= 25)));
            check("held_busy0", 32'(w0[27]), 32'(i != 24));
            check("held_busy1", 32'(w1[27]), 32'(i != 24));
            if (i < 26) tick();
        end
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_led", 32'(ledMotorOut), 32'h0);
        check("async_rst_busy", 32'({w1[27], w0[27]}), 32'h0);
        mmioBoardOutput = '0;
        @(negedge fastClock);
        reset = 1'b1;
        n = 0;
        #1;
        check("rerel_w0", w0, 32'h0);
        check("rerel_w1", w1, 32'h0400_0000);
        repeat (3) tick();
        check("no_resume_led", 32'(ledMotorOut), 32'h0);
        check("no_resume_busy", 32'({w1[27], w0[27]}), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
